melody_sequencer: RTL

Controller that steps the 2-bit melody ROM through its addresses. It holds each fetched note for a fixed number of clock ticks and inserts a silent gap between notes, then stops or loops. It drives the tone generator's note select and enable, and gives the top level a start/stop/busy/done interface. It sits between the melody ROM and the tone (DAC waveform) generator.

---
 rtl/melody_pkg.sv | 29 ++
 rtl/tick_counter.sv | 27 ++
 rtl/melody_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/melody_pkg.sv
// Shared types and defaults for the melody sequencer: state encoding, rest code,
// default widths/tick counts and the counter-width helper.
package melody_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        PLAY  = 3'd3,
        GAP   = 3'd4
    } state_t;

    localparam int unsigned NOTE_REST        = 0;
    localparam int unsigned DEF_ADDR_W       = 3;
    localparam int unsigned DEF_NOTE_W       = 2;
    localparam int unsigned DEF_MELODY_LEN   = 7;
    localparam int unsigned DEF_NOTE_TICKS   = 12500000;
    localparam int unsigned DEF_GAP_TICKS    = 1250000;

    // Tick counter width: enough bits for the longer of the two durations, never below 1.
    function automatic int unsigned cnt_width(input int unsigned note_ticks,
                                              input int unsigned gap_ticks);
        int unsigned m;
        m = (note_ticks > gap_ticks) ? note_ticks : gap_ticks;
        if (m < 2) m = 2;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/tick_counter.sv
// Loadable down-counter that saturates at zero; times both note and gap durations.
module tick_counter #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    output logic         expired_c
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign expired_c = (count == '0);

endmodule

// File: rtl/melody_sequencer.sv
// Steps the melody ROM, holds each note for NOTE_TICKS, inserts a GAP_TICKS silence,
// then loops or finishes with a one-cycle done pulse.
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned NOTE_W     = DEF_NOTE_W,
    parameter int unsigned MELODY_LEN = DEF_MELODY_LEN,
    parameter int unsigned NOTE_TICKS = DEF_NOTE_TICKS,
    parameter int unsigned GAP_TICKS  = DEF_GAP_TICKS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [NOTE_W-1:0] rom_q,
    output logic [NOTE_W-1:0] note,
    output logic              tone_en,
    output logic              busy,
    output logic              done
);

    localparam int unsigned       CNT_W     = cnt_width(NOTE_TICKS, GAP_TICKS);
    localparam logic [CNT_W-1:0]  NOTE_LOAD = CNT_W'(NOTE_TICKS - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'((GAP_TICKS == 0) ? 0 : GAP_TICKS - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MELODY_LEN - 1);

    state_t              state, state_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [NOTE_W-1:0]   note_d;
    logic                tone_d, done_d;
    logic                cnt_load, cnt_en, expired_c;
    logic [CNT_W-1:0]    cnt_value;
    logic                abort_c, last_c, advance_c;

    tick_counter #(.W(CNT_W)) u_tick (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (cnt_value),
        .enable     (cnt_en),
        .expired_c  (expired_c)
    );

    assign abort_c   = stop && (state != IDLE);
    assign last_c    = (rom_addr == LAST_ADDR);
    // End of a note slot: after PLAY when there is no gap, otherwise after GAP.
    assign advance_c = !abort_c && expired_c &&
                       (((state == PLAY) && (GAP_TICKS == 0)) || (state == GAP));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (abort_c) begin
            state_d = IDLE;
        end else if (advance_c) begin
            state_d = (last_c && !loop_en) ? IDLE : FETCH;
        end else begin
            case (state)
                IDLE:    if (start && !stop) state_d = FETCH;
                FETCH:   state_d = WAIT;
                WAIT:    state_d = PLAY;
                PLAY:    if (expired_c) state_d = GAP;
                GAP:     state_d = GAP;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        addr_d    = rom_addr;
        note_d    = note;
        tone_d    = tone_en;
        done_d    = 1'b0;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        cnt_value = NOTE_LOAD;
        if (abort_c) begin
            addr_d = '0;
            note_d = '0;
            tone_d = 1'b0;
        end else begin
            case (state)
                IDLE: addr_d = '0;
                WAIT: begin
                    note_d   = rom_q;
                    tone_d   = (rom_q != NOTE_W'(NOTE_REST));
                    cnt_load = 1'b1;
                end
                PLAY: begin
                    cnt_en = 1'b1;
                    if (expired_c) begin
                        tone_d = 1'b0;
                        if (GAP_TICKS != 0) begin
                            cnt_load  = 1'b1;
                            cnt_value = GAP_LOAD;
                        end
                    end
                end
                GAP:     cnt_en = 1'b1;
                default: ;
            endcase
            if (advance_c) begin
                if (!last_c) begin
                    addr_d = rom_addr + ADDR_W'(1);
                end else begin
                    addr_d = '0;
                    if (!loop_en) begin
                        note_d = '0;
                        done_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_addr <= '0;
            note     <= '0;
            tone_en  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            rom_addr <= addr_d;
            note     <= note_d;
            tone_en  <= tone_d;
            busy     <= (state_d != IDLE);
            done     <= done_d;
        end
    end

endmodule
